// File: rtl/ctrl_pkg.sv
// Shared types and constants for the serial controller reader.
// The optional CTRL_DEBOUNCE_EN macro is consumed by ctrl_serial_reader.
package ctrl_pkg;

  localparam int unsigned CTRL_NUM_BTNS = 8;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StShiftLo,
    StShiftHi,
    StDone
  } ctrl_state_e;

  // Counter width for a modulus of n; never zero so N=1 still gets a real register.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctrl_halfbit_timer.sv
// Modulo-N cycle counter: asserts last on count N-1 while enabled, restarts on load.
module ctrl_halfbit_timer
  import ctrl_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic load,
  output logic last
);

  localparam int unsigned W = cnt_width(N);
  localparam logic [W-1:0] LastVal = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign last = en && (cnt_q == LastVal);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ctrl_serial_reader.sv
// NES-style pad scanner publishing {sticky press edges, button state}.
// Define CTRL_DEBOUNCE_EN to commit a scan only when it matches the previous scan.
module ctrl_serial_reader
  import ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned POLL_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_data,
  output logic        ctrl_latch,
  output logic        ctrl_clk,
  input  logic        ack,
  output logic [7:0]  buttons,
  output logic [7:0]  edges,
  output logic        valid,
  output logic [15:0] game_word
);

  localparam int unsigned IdleW = cnt_width(POLL_PERIOD);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(POLL_PERIOD - 1);
  localparam int unsigned IdxW = $clog2(CTRL_NUM_BTNS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(CTRL_NUM_BTNS - 1);

  ctrl_state_e state_q, state_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] buttons_q, buttons_d;
  logic [7:0] edges_q, edges_d;
  logic valid_q, latch_q, sclk_q;
  logic done, commit, state_change;
  logic latch_last, bit_last;

  assign state_change = (state_d != state_q);

  ctrl_halfbit_timer #(
    .N (2 * CLK_DIV)
  ) u_latch_timer (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == StLatch),
    .load  (state_change),
    .last  (latch_last)
  );

  ctrl_halfbit_timer #(
    .N (CLK_DIV)
  ) u_shift_timer (
    .clk   (clk),
    .reset (reset),
    .en    ((state_q == StShiftLo) || (state_q == StShiftHi)),
    .load  (state_change),
    .last  (bit_last)
  );

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (idle_cnt_q == IdleLast) begin
          idle_cnt_d = '0;
          state_d    = StLatch;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      StLatch: begin
        if (latch_last) begin
          idx_d   = '0;
          state_d = StShiftLo;
        end
      end
      StShiftLo: begin
        // Sample at the end of the low phase, just before the pad sees the rising edge.
        if (bit_last) begin
          shift_d[idx_q] = ~ctrl_data;
          state_d        = StShiftHi;
        end
      end
      StShiftHi: begin
        if (bit_last) begin
          if (idx_q == IdxLast) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StShiftLo;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef CTRL_DEBOUNCE_EN
  logic [7:0] prev_shift_q;

  assign commit = done && (shift_q == prev_shift_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_shift_q <= '0;
    end else if (done) begin
      prev_shift_q <= shift_q;
    end
  end
`else
  assign commit = done;
`endif

  // Ack clears first, so a press committed in the same cycle still lands.
  always_comb begin
    buttons_d = commit ? shift_q : buttons_q;
    edges_d   = (ack ? 8'h00 : edges_q) | (commit ? (shift_q & ~buttons_q) : 8'h00);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idle_cnt_q <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      buttons_q  <= '0;
      edges_q    <= '0;
      valid_q    <= 1'b0;
      latch_q    <= 1'b0;
      sclk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      buttons_q  <= buttons_d;
      edges_q    <= edges_d;
      valid_q    <= done;
      latch_q    <= (state_d == StLatch);
      sclk_q     <= (state_d == StShiftHi);
    end
  end

  assign ctrl_latch = latch_q;
  assign ctrl_clk   = sclk_q;
  assign buttons    = buttons_q;
  assign edges      = edges_q;
  assign valid      = valid_q;
  assign game_word  = {edges_q, buttons_q};

endmodule

// File: tb/tb_ctrl_serial_reader.sv
// Self-checking bench for ctrl_serial_reader with a pad model and a per-scan reference model.
module tb_ctrl_serial_reader;

  localparam int unsigned ClkDiv = 2;
  localparam int unsigned PollPeriod = 10;
  localparam int ScanLen = 18 * ClkDiv + 1;
  localparam int PollInt = ScanLen + PollPeriod;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ack = 1'b0;
  logic        ctrl_data;
  logic        ctrl_latch;
  logic        ctrl_clk;
  logic [7:0]  buttons;
  logic [7:0]  edges;
  logic        valid;
  logic [15:0] game_word;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] pad_pat = 8'h00;
  int pad_idx = 0;

  logic [7:0] exp_buttons = 8'h00;
  logic [7:0] exp_edges = 8'h00;
`ifdef CTRL_DEBOUNCE_EN
  logic [7:0] prev_scan = 8'h00;
`endif

  ctrl_serial_reader #(
    .CLK_DIV     (ClkDiv),
    .POLL_PERIOD (PollPeriod)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl_data  (ctrl_data),
    .ctrl_latch (ctrl_latch),
    .ctrl_clk   (ctrl_clk),
    .ack        (ack),
    .buttons    (buttons),
    .edges      (edges),
    .valid      (valid),
    .game_word  (game_word)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 4021-style pad: latch reloads bit 0, each ctrl_clk rise advances one bit.
  always @(posedge ctrl_latch or posedge ctrl_clk) begin
    if (ctrl_latch) pad_idx = 0;
    else pad_idx = pad_idx + 1;
  end

  assign ctrl_data = (pad_idx < 8) ? ~pad_pat[pad_idx[2:0]] : 1'b0;

  task automatic model_commit(input logic [7:0] pat, input bit ack_now);
    bit do_commit;
`ifdef CTRL_DEBOUNCE_EN
    do_commit = (pat == prev_scan);
    prev_scan = pat;
`else
    do_commit = 1'b1;
`endif
    if (ack_now) exp_edges = 8'h00;
    if (do_commit) begin
      exp_edges   = exp_edges | (pat & ~exp_buttons);
      exp_buttons = pat;
    end
  endtask

  task automatic model_reset();
    exp_buttons = 8'h00;
    exp_edges   = 8'h00;
`ifdef CTRL_DEBOUNCE_EN
    prev_scan = 8'h00;
`endif
  endtask

  // Drives one full scan of pat; n = cycles from latch rise to valid (0 or >ScanLen on timeout).
  task automatic run_scan(input logic [7:0] pat, input bit ack_done, output int n,
                          output int rise_cyc);
    int guard;
    pad_pat  = pat;
    n        = 0;
    rise_cyc = 0;
    guard    = 0;
    while (ctrl_latch !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (ctrl_latch !== 1'b1) return;
    rise_cyc = cyc;
    while (valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      ack = (ack_done && n == ScanLen - 1);
    end
    ack = 1'b0;
    if (valid === 1'b1) model_commit(pat, ack_done);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    exp_edges = 8'h00;
  endtask

  task automatic test_reset();
    int n, hi, guard, pulses, len;
    reset   = 1'b0;
    pad_pat = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({ctrl_latch, ctrl_clk, valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: latch/clk/valid=%b expected 000", {ctrl_latch, ctrl_clk, valid});
    end
    checks++;
    if ({buttons, edges, game_word} !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: buttons=%h edges=%h word=%h expected 0", buttons, edges, game_word);
    end
    reset = 1'b1;
    n = 0;
    while (ctrl_latch !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != PollPeriod) begin
      failures++;
      $display("FAIL first_latch: %0d cycles expected %0d", n, PollPeriod);
    end
    hi = 0;
    while (ctrl_latch === 1'b1 && hi < 100) begin
      @(negedge clk);
      hi++;
    end
    checks++;
    if (hi != 2 * ClkDiv) begin
      failures++;
      $display("FAIL latch_width: %0d cycles expected %0d", hi, 2 * ClkDiv);
    end
    pulses = 0;
    len = 0;
    guard = 0;
    while (valid !== 1'b1 && guard < 200) begin
      if (ctrl_clk === 1'b1) begin
        len++;
      end else if (len != 0) begin
        pulses++;
        checks++;
        if (len != ClkDiv) begin
          failures++;
          $display("FAIL clk_pulse_width: pulse %0d is %0d cycles expected %0d", pulses, len, ClkDiv);
        end
        len = 0;
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (pulses != 8) begin
      failures++;
      $display("FAIL clk_pulse_count: %0d expected 8", pulses);
    end
    checks++;
    if (hi + guard != ScanLen) begin
      failures++;
      $display("FAIL first_scan_len: %0d expected %0d", hi + guard, ScanLen);
    end
    model_commit(8'h00, 1'b0);
  endtask

  task automatic test_pattern();
    int n, rc;
    run_scan(8'h81, 1'b0, n, rc);
    checks++;
    if (n != ScanLen) begin
      failures++;
      $display("FAIL pattern_latency: valid at %0d expected %0d", n, ScanLen);
    end
    checks++;
    if (buttons !== exp_buttons || edges !== exp_edges) begin
      failures++;
      $display("FAIL pattern_state: buttons=%h edges=%h expected %h %h",
               buttons, edges, exp_buttons, exp_edges);
    end
    checks++;
    if (game_word !== {exp_edges, exp_buttons}) begin
      failures++;
      $display("FAIL pattern_word: %h expected %h", game_word, {exp_edges, exp_buttons});
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_width: valid=%b one cycle after pulse expected 0", valid);
    end
  endtask

  task automatic test_ack_hold();
    int n, rc;
    run_scan(8'h81, 1'b0, n, rc);
    pulse_ack();
    checks++;
    if (edges !== 8'h00 || buttons !== exp_buttons) begin
      failures++;
      $display("FAIL ack_clear: edges=%h buttons=%h expected 00 %h", edges, buttons, exp_buttons);
    end
    run_scan(8'h81, 1'b0, n, rc);
    checks++;
    if (edges !== exp_edges) begin
      failures++;
      $display("FAIL hold_no_edge: edges=%h expected %h", edges, exp_edges);
    end
    run_scan(8'h83, 1'b0, n, rc);
    checks++;
    if (edges !== exp_edges || buttons !== exp_buttons) begin
      failures++;
      $display("FAIL new_press: edges=%h buttons=%h expected %h %h",
               edges, buttons, exp_edges, exp_buttons);
    end
  endtask

  task automatic test_simultaneous();
    int n, rc;
    run_scan(8'h00, 1'b0, n, rc);
    pulse_ack();
    run_scan(8'h01, 1'b0, n, rc);
    run_scan(8'h00, 1'b0, n, rc);
    checks++;
    if (edges !== exp_edges || buttons !== exp_buttons) begin
      failures++;
      $display("FAIL release_no_edge: edges=%h buttons=%h expected %h %h",
               edges, buttons, exp_edges, exp_buttons);
    end
    run_scan(8'h10, 1'b1, n, rc);
    checks++;
    if (edges !== exp_edges || buttons !== exp_buttons) begin
      failures++;
      $display("FAIL ack_and_commit: edges=%h buttons=%h expected %h %h",
               edges, buttons, exp_edges, exp_buttons);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2, rc1, rc2;
    run_scan(8'h24, 1'b0, n1, rc1);
    run_scan(8'h24, 1'b0, n2, rc2);
    checks++;
    if (rc2 - rc1 != PollInt) begin
      failures++;
      $display("FAIL poll_interval: %0d cycles expected %0d", rc2 - rc1, PollInt);
    end
  endtask

  task automatic test_random();
    int n, rc;
    logic [7:0] pat;
    logic [7:0] last_pat;
    int mode;
    last_pat = exp_buttons;
    for (int i = 0; i < 24; i++) begin
      pat  = ($urandom_range(0, 2) == 0) ? last_pat : 8'($urandom);
      mode = $urandom_range(0, 3);
      if (mode == 2) pulse_ack();
      run_scan(pat, mode == 1, n, rc);
      last_pat = pat;
      checks++;
      if (n != ScanLen) begin
        failures++;
        $display("FAIL rand_latency[%0d]: %0d expected %0d", i, n, ScanLen);
      end
      checks++;
      if (buttons !== exp_buttons) begin
        failures++;
        $display("FAIL rand_buttons[%0d]: %h expected %h", i, buttons, exp_buttons);
      end
      checks++;
      if (edges !== exp_edges) begin
        failures++;
        $display("FAIL rand_edges[%0d]: %h expected %h", i, edges, exp_edges);
      end
      checks++;
      if (game_word !== {exp_edges, exp_buttons}) begin
        failures++;
        $display("FAIL rand_word[%0d]: %h expected %h", i, game_word, {exp_edges, exp_buttons});
      end
    end
  endtask

`ifdef CTRL_DEBOUNCE_EN
  task automatic test_debounce();
    int n, rc;
    logic [7:0] seq [5];
    logic [7:0] want [5];
    seq  = '{8'h04, 8'h00, 8'h04, 8'h04, 8'h04};
    want = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h04};
    run_scan(8'h00, 1'b0, n, rc);
    run_scan(8'h00, 1'b0, n, rc);
    for (int i = 0; i < 5; i++) begin
      run_scan(seq[i], 1'b0, n, rc);
      checks++;
      if (buttons !== want[i] || buttons !== exp_buttons) begin
        failures++;
        $display("FAIL debounce[%0d]: buttons=%h expected %h", i, buttons, want[i]);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_scan();
    int n, rc, guard;
    run_scan(8'h00, 1'b0, n, rc);
    run_scan(8'h00, 1'b0, n, rc);
    pad_pat = 8'hFF;
    guard = 0;
    while (ctrl_latch !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    n = 0;
    while (n < 18) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ctrl_clk !== 1'b1) begin
      failures++;
      $display("FAIL mid_scan_phase: ctrl_clk=%b expected 1 in bit 3 high phase", ctrl_clk);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({ctrl_clk, ctrl_latch, valid} !== 3'b000 || buttons !== 8'h00) begin
      failures++;
      $display("FAIL mid_scan_reset: clk/latch/valid=%b buttons=%h expected 000 00",
               {ctrl_clk, ctrl_latch, valid}, buttons);
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (ctrl_latch !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != PollPeriod) begin
      failures++;
      $display("FAIL relatch_after_reset: %0d cycles expected %0d", n, PollPeriod);
    end
    n = 0;
    while (valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    model_commit(8'hFF, 1'b0);
    checks++;
    if (n != ScanLen || buttons !== exp_buttons || edges !== exp_edges) begin
      failures++;
      $display("FAIL post_reset_scan: len=%0d buttons=%h edges=%h expected %0d %h %h",
               n, buttons, edges, ScanLen, exp_buttons, exp_edges);
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_ack_hold();
    test_simultaneous();
    test_back_to_back();
    test_random();
`ifdef CTRL_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
